majority_bist: RTL and testbench

Synthesizable on-chip exhaustive tester for the 3-input majority function. It drives all eight `{a,b,c}` vectors into an external majority DUT and samples the DUT output after a programmable settle time. Each sample is compared against an internal golden majority. The block reports pass/fail, an error count and the first failing vector. It is the hardware counterpart of the simulation bench: it sits beside the majority DUT, owns the DUT inputs and receives the DUT output.

---
 rtl/majority_bist.sv | 113 +++++++++++
 tb/tb_majority_bist.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/majority_bist.sv
// Exhaustive in-system tester for an external 3-input majority block.
// Steps {a,b,c} through 000..111, checks m_in after a settle time, and logs errors.
module majority_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  input  logic                 m_in,
  output logic                 exp_m,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [2:0]           first_fail_vec,
  output logic                 first_fail_m
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic          first_err;
  logic          settle_end;
  logic          mismatch;

  assign exp_m      = (a & b) | (b & c) | (a & c);
  assign settle_end = (cnt == CW'(SETTLE_CYCLES - 1));
  assign mismatch   = (state == CHECK) && (m_in != exp_m);
  assign busy       = (state == SETTLE) || (state == CHECK);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: if (settle_end) state_nxt = CHECK;
      CHECK:  state_nxt = (idx == 3'd7) ? DONE : SETTLE;
      DONE:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {a, b, c}      <= 3'b000;
      idx            <= 3'd0;
      cnt            <= '0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_vec <= 3'b000;
      first_fail_m   <= 1'b0;
      first_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            {a, b, c}      <= 3'b000;
            idx            <= 3'd0;
            cnt            <= '0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vec <= 3'b000;
            first_fail_m   <= 1'b0;
            first_err      <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_end) cnt <= '0;
          else            cnt <= cnt + CW'(1);
        end
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
            if (!first_err) begin
              first_fail_vec <= {a, b, c};
              first_fail_m   <= m_in;
              first_err      <= 1'b1;
            end
          end
          if (idx != 3'd7) begin
            idx       <= idx + 3'd1;
            {a, b, c} <= idx + 3'd1;
          end else begin
            // a mismatch on the last vector must still fail the run
            pass <= (err_cnt == '0) && !mismatch;
          end
        end
        DONE: begin
          {a, b, c} <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_majority_bist.sv
// Self-checking bench for majority_bist: table, random-fault and timing
// sequences against a reference model of the majority tester.
module tb_majority_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;

  logic a1, b1, c1, em1, busy1, done1, pass1, ffm1, m1;
  logic [3:0] err1;
  logic [2:0] ffv1;
  logic a3, b3, c3, em3, busy3, done3, pass3, ffm3, m3;
  logic [3:0] err3;
  logic [2:0] ffv3;

  logic [7:0] mask = 8'h00;
  logic delay1 = 1'b0;
  logic r1a = 1'b0, r1b = 1'b0, r3a = 1'b0, r3b = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] mask;
    int err;
    int ffv;
    int ffm;
    int pass;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  function automatic logic maj3(input logic [2:0] v);
    return $countones(v) >= 2;
  endfunction

  always @(posedge clk) begin
    r1a <= maj3({a1, b1, c1});
    r1b <= r1a;
    r3a <= maj3({a3, b3, c3});
    r3b <= r3a;
  end

  always_comb begin
    m1 = delay1 ? r1b : (maj3({a1, b1, c1}) ^ mask[{a1, b1, c1}]);
    m3 = r3b;
  end

  majority_bist #(.SETTLE_CYCLES(1), .ERR_CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .m_in(m1), .exp_m(em1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_fail_vec(ffv1), .first_fail_m(ffm1)
  );

  majority_bist #(.SETTLE_CYCLES(3), .ERR_CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .a(a3), .b(b3), .c(c3), .m_in(m3), .exp_m(em3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .first_fail_vec(ffv3), .first_fail_m(ffm3)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_res(input bit sel, input string nm,
                         input int e_err, input int e_ffv,
                         input int e_ffm, input int e_pass);
    chk({nm, ".err_cnt"}, sel ? int'(err3) : int'(err1), e_err);
    chk({nm, ".pass"}, sel ? int'(pass3) : int'(pass1), e_pass);
    if (e_err != 0) begin
      chk({nm, ".ffv"}, sel ? int'(ffv3) : int'(ffv1), e_ffv);
      chk({nm, ".ffm"}, sel ? int'(ffm3) : int'(ffm1), e_ffm);
    end else begin
      chk({nm, ".ffv_clr"}, sel ? int'(ffv3) : int'(ffv1), 0);
      chk({nm, ".ffm_clr"}, sel ? int'(ffm3) : int'(ffm1), 0);
    end
  endtask

  // one complete run, checking stepping, busy, exp_m and done timing
  task automatic run(input bit sel, input bit noisy);
    int s;
    int lim;
    int ndone;
    int dcyc;
    logic [2:0] v;
    s = sel ? 3 : 1;
    lim = 8 * (s + 1);
    ndone = 0;
    dcyc = -1;
    @(negedge clk);
    if (sel) start3 = 1'b1;
    else     start1 = 1'b1;
    for (int i = 1; i <= lim + 6; i++) begin
      @(negedge clk);
      if (sel) start3 = 1'b0;
      else     start1 = noisy && (i < lim) ? 1'($urandom) : 1'b0;
      v = sel ? {a3, b3, c3} : {a1, b1, c1};
      if (i == 1) begin
        chk("clr.pass", sel ? int'(pass3) : int'(pass1), 0);
        chk("clr.err", sel ? int'(err3) : int'(err1), 0);
        chk("clr.ffv", sel ? int'(ffv3) : int'(ffv1), 0);
        chk("clr.ffm", sel ? int'(ffm3) : int'(ffm1), 0);
      end
      if (i - 1 < lim) begin
        chk("vec", int'(v), (i - 1) / (s + 1));
        chk("busy", sel ? int'(busy3) : int'(busy1), 1);
        chk("exp_m", sel ? int'(em3) : int'(em1), int'(maj3(v)));
      end
      if (sel ? done3 : done1) begin
        ndone++;
        if (dcyc < 0) dcyc = i;
      end
    end
    chk("done_cnt", ndone, 1);
    chk("done_time", dcyc, lim + 1);
    chk("idle_busy", sel ? int'(busy3) : int'(busy1), 0);
  endtask

  initial begin
    int e_err, e_ffv, e_ffm, cnt;
    bit found;

    tbl[0] = '{8'h00, 0, 0, 0, 1};
    tbl[1] = '{8'hE8, 4, 3, 0, 0};
    tbl[2] = '{8'hFF, 8, 0, 1, 0};
    tbl[3] = '{8'h00, 0, 0, 0, 1};
    tbl[4] = '{8'h80, 1, 7, 0, 0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.abc", int'({a1, b1, c1}), 0);
    chk("rst.busy", int'(busy1), 0);
    chk("rst.done", int'(done1), 0);
    chk("rst.pass", int'(pass1), 0);
    chk("rst.err", int'(err1), 0);
    chk("rst.ffv", int'(ffv1), 0);
    chk("rst.ffm", int'(ffm1), 0);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      mask = tbl[t].mask;
      run(1'b0, t[0]);
      chk_res(1'b0, "tbl", tbl[t].err, tbl[t].ffv, tbl[t].ffm, tbl[t].pass);
    end

    for (int r = 0; r < 6; r++) begin
      mask = 8'($urandom);
      e_err = $countones(mask);
      e_ffv = 0;
      found = 1'b0;
      for (int k = 0; k < 8; k++)
        if (mask[k] && !found) begin
          e_ffv = k;
          found = 1'b1;
        end
      e_ffm = int'(!maj3(3'(e_ffv)));
      run(1'b0, 1'b1);
      chk_res(1'b0, "rnd", e_err, e_ffv, e_ffm, int'(e_err == 0));
    end

    // start held high: one done, then re-trigger from the following IDLE cycle
    mask = 8'h00;
    @(negedge clk);
    start1 = 1'b1;
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done1) found = 1'b1;
      cnt++;
    end
    chk("hold.done_seen", int'(found), 1);
    chk("hold.done_time", cnt, 17);
    @(negedge clk);
    chk("hold.idle_busy", int'(busy1), 0);
    chk("hold.idle_done", int'(done1), 0);
    @(negedge clk);
    chk("hold.restart", int'(busy1), 1);
    start1 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1) cnt++;
    end
    chk("hold.one_done", cnt, 1);
    chk_res(1'b0, "hold", 0, 0, 0, 1);

    // reset while vector 100 settles
    mask = 8'hFF;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if ({a1, b1, c1} == 3'b100) found = 1'b1;
      else @(negedge clk);
    end
    chk("mid.reached", int'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid.abc", int'({a1, b1, c1}), 0);
    chk("mid.busy", int'(busy1), 0);
    chk("mid.err", int'(err1), 0);
    chk("mid.ffv", int'(ffv1), 0);
    chk("mid.ffm", int'(ffm1), 0);
    chk("mid.pass", int'(pass1), 0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1 || busy1) cnt++;
    end
    chk("mid.no_done", cnt, 0);
    chk("mid.pass_hold", int'(pass1), 0);
    mask = 8'h00;
    run(1'b0, 1'b0);
    chk_res(1'b0, "mid.rerun", 0, 0, 0, 1);

    // reset beats a simultaneous start
    rst_n = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start1 = 1'b0;
    chk("rst_win.busy", int'(busy1), 0);
    chk("rst_win.pass", int'(pass1), 0);
    @(negedge clk);
    chk("rst_win.idle", int'(busy1), 0);

    // two-register DUT: too fast with 1 settle cycle, fine with 3
    delay1 = 1'b1;
    run(1'b0, 1'b0);
    chk_res(1'b0, "dly1", 3, 3, 0, 0);
    delay1 = 1'b0;
    run(1'b1, 1'b0);
    chk_res(1'b1, "dly3", 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
